// File: rtl/vliw_pkg.sv
// Shared constants and types for the VLIW decode->execute bundle register.
// Slot order within a bundle is fixed here and used by every consumer.
package vliw_pkg;

  localparam int NUM_SLOTS = 4;
  localparam int SLOT_IXU1 = 0;
  localparam int SLOT_IXU2 = 1;
  localparam int SLOT_LSU  = 2;
  localparam int SLOT_BRU  = 3;
  localparam int REG_W     = 5;
  localparam int PC_W      = 32;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } stall_state_e;

  // A write to r0 is architecturally a no-op, so it can never be a load-use producer.
  function automatic logic lsu_load_q(input logic slot_valid,
                                      input logic [REG_W-1:0] rd,
                                      input logic is_load);
    return slot_valid & is_load & (rd != '0);
  endfunction

endpackage

// File: rtl/dc_ex_stall_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 15
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_count,
  output logic             o_at_max
);

  logic [WIDTH-1:0] r_count;
  logic             w_at_max;

  assign w_at_max = (r_count == WIDTH'(MAX));

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_count <= '0;
    end else if (i_inc && !w_at_max) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count  = r_count;
  assign o_at_max = w_at_max;

endmodule

// File: rtl/dc_ex_stall_reg.sv
// Decode->execute bundle register with stall bubbles, flush squash and stall watchdog.
// Optional performance counters are built when STALL_PERF_CNT_EN is defined.
module dc_ex_stall_reg
  import vliw_pkg::*;
#(
  parameter int SLOT_W       = 64,
  parameter int FLUSH_CYCLES = 1,
  parameter int MAX_STALL    = 15
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_stall_in,
  input  logic                          i_flush_in,
  input  logic [NUM_SLOTS-1:0]          i_dc_slot_valid,
  input  logic [NUM_SLOTS*SLOT_W-1:0]   i_dc_bundle,
  input  logic [PC_W-1:0]               i_dc_pc,
  input  logic [REG_W-1:0]              i_dc_lsu_rd,
  input  logic                          i_dc_lsu_is_load,
  output logic                          o_dc_hold,
  output logic [NUM_SLOTS-1:0]          o_ex_slot_valid,
  output logic [NUM_SLOTS*SLOT_W-1:0]   o_ex_bundle,
  output logic [PC_W-1:0]               o_ex_pc,
  output logic [REG_W-1:0]              o_lsu_ex_rd,
  output logic                          o_lsu_ex_is_load,
  output logic                          o_stall_timeout,
  output logic [31:0]                   o_perf_stall_cnt,
  output logic [31:0]                   o_perf_flush_cnt,
  output stall_state_e                  o_dbg_state,
  output logic [$clog2(MAX_STALL+1)-1:0] o_dbg_stall_cnt
);

  localparam int FCNT_W = $clog2(FLUSH_CYCLES + 1);
  localparam int SCNT_W = $clog2(MAX_STALL + 1);
  localparam logic [FCNT_W-1:0] FLUSH_RELOAD = FCNT_W'(FLUSH_CYCLES - 1);

  stall_state_e                r_state;
  stall_state_e                w_state_nxt;
  logic [FCNT_W-1:0]           r_flush_cnt;
  logic [FCNT_W-1:0]           w_flush_cnt_nxt;
  logic                        w_bubble;
  logic                        w_stall_eff;
  logic                        w_stall_at_max;
  logic [SCNT_W-1:0]           w_stall_cnt;

  logic [NUM_SLOTS-1:0]        r_ex_slot_valid;
  logic [NUM_SLOTS*SLOT_W-1:0] r_ex_bundle;
  logic [PC_W-1:0]             r_ex_pc;
  logic [REG_W-1:0]            r_lsu_ex_rd;
  logic                        r_lsu_ex_is_load;
  logic                        r_stall_timeout;

  // Flow contract: the decode bundle is consumed on every cycle o_dc_hold is low
  // (as if ready=1); while o_dc_hold is high decode must present the same bundle
  // again and EX receives a bubble. A flush discards the bundle, so hold drops.
  assign w_stall_eff = i_stall_in & ~i_flush_in;
  assign o_dc_hold   = w_stall_eff & ~i_rst & (r_state != FLUSH);

  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    w_bubble        = 1'b0;
    case (r_state)
      RUN, STALL: begin
        if (i_flush_in) begin
          w_bubble        = 1'b1;
          w_flush_cnt_nxt = FLUSH_RELOAD;
          w_state_nxt     = (FLUSH_CYCLES == 1) ? RUN : FLUSH;
        end else if (i_stall_in) begin
          w_bubble    = 1'b1;
          w_state_nxt = STALL;
        end else begin
          w_state_nxt = RUN;
        end
      end
      FLUSH: begin
        // The flush cycle itself is the first bubble; the count covers the rest.
        w_bubble = 1'b1;
        if (i_flush_in) begin
          w_flush_cnt_nxt = FLUSH_RELOAD;
          w_state_nxt     = (FLUSH_CYCLES == 1) ? RUN : FLUSH;
        end else if (r_flush_cnt <= FCNT_W'(1)) begin
          w_flush_cnt_nxt = '0;
          w_state_nxt     = RUN;
        end else begin
          w_flush_cnt_nxt = r_flush_cnt - FCNT_W'(1);
        end
      end
      default: begin
        w_bubble    = 1'b1;
        w_state_nxt = RUN;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state          <= RUN;
      r_flush_cnt      <= '0;
      r_ex_slot_valid  <= '0;
      r_ex_bundle      <= '0;
      r_ex_pc          <= '0;
      r_lsu_ex_rd      <= '0;
      r_lsu_ex_is_load <= 1'b0;
      r_stall_timeout  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      if (w_bubble) begin
        r_ex_slot_valid  <= '0;
        r_lsu_ex_rd      <= '0;
        r_lsu_ex_is_load <= 1'b0;
      end else begin
        r_ex_slot_valid  <= i_dc_slot_valid;
        r_ex_bundle      <= i_dc_bundle;
        r_ex_pc          <= i_dc_pc;
        r_lsu_ex_rd      <= i_dc_slot_valid[SLOT_LSU] ? i_dc_lsu_rd : '0;
        r_lsu_ex_is_load <= lsu_load_q(i_dc_slot_valid[SLOT_LSU], i_dc_lsu_rd, i_dc_lsu_is_load);
      end
      r_stall_timeout <= r_stall_timeout | (w_stall_at_max & w_stall_eff);
    end
  end

  sat_counter #(
    .WIDTH (SCNT_W),
    .MAX   (MAX_STALL)
  ) u_stall_cnt (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_inc    (w_stall_eff),
    .i_clr    (~w_stall_eff),
    .o_count  (w_stall_cnt),
    .o_at_max (w_stall_at_max)
  );

`ifdef STALL_PERF_CNT_EN
  logic [31:0] r_perf_stall_cnt;
  logic [31:0] r_perf_flush_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_perf_stall_cnt <= '0;
      r_perf_flush_cnt <= '0;
    end else begin
      if (o_dc_hold)  r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      if (i_flush_in) r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
    end
  end

  assign o_perf_stall_cnt = r_perf_stall_cnt;
  assign o_perf_flush_cnt = r_perf_flush_cnt;
`else
  assign o_perf_stall_cnt = '0;
  assign o_perf_flush_cnt = '0;
`endif

  assign o_ex_slot_valid  = r_ex_slot_valid;
  assign o_ex_bundle      = r_ex_bundle;
  assign o_ex_pc          = r_ex_pc;
  assign o_lsu_ex_rd      = r_lsu_ex_rd;
  assign o_lsu_ex_is_load = r_lsu_ex_is_load;
  assign o_stall_timeout  = r_stall_timeout;
  assign o_dbg_state      = r_state;
  assign o_dbg_stall_cnt  = w_stall_cnt;

endmodule

// File: tb/tb_dc_ex_stall_reg.sv
// Self-checking bench for dc_ex_stall_reg (FLUSH_CYCLES=2, MAX_STALL=15); honours STALL_PERF_CNT_EN.
module tb_dc_ex_stall_reg;
  import vliw_pkg::*;

  localparam int SLOT_W = 64;
  localparam int BW     = NUM_SLOTS * SLOT_W;
  localparam int EW     = NUM_SLOTS + PC_W + REG_W + 1;

  logic                 clk;
  logic                 rst;
  logic                 stall_in;
  logic                 flush_in;
  logic [NUM_SLOTS-1:0] dc_slot_valid;
  logic [BW-1:0]        dc_bundle;
  logic [PC_W-1:0]      dc_pc;
  logic [REG_W-1:0]     dc_lsu_rd;
  logic                 dc_lsu_is_load;
  logic                 dc_hold;
  logic [NUM_SLOTS-1:0] ex_slot_valid;
  logic [BW-1:0]        ex_bundle;
  logic [PC_W-1:0]      ex_pc;
  logic [REG_W-1:0]     lsu_ex_rd;
  logic                 lsu_ex_is_load;
  logic                 stall_timeout;
  logic [31:0]          perf_stall_cnt;
  logic [31:0]          perf_flush_cnt;
  stall_state_e         dbg_state;
  logic [3:0]           dbg_stall_cnt;

  logic [EW-1:0] exp_q[$];
  logic [BW-1:0] exp_bq[$];
  logic [EW-1:0] w_obs;
  logic [EW-1:0] e;
  logic [BW-1:0] eb;
  int            n_checks;
  int            n_errors;
  logic [31:0]   exp_perf_stall;

  assign w_obs = {ex_slot_valid, ex_pc, lsu_ex_rd, lsu_ex_is_load};

  dc_ex_stall_reg #(
    .SLOT_W       (SLOT_W),
    .FLUSH_CYCLES (2),
    .MAX_STALL    (15)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_stall_in       (stall_in),
    .i_flush_in       (flush_in),
    .i_dc_slot_valid  (dc_slot_valid),
    .i_dc_bundle      (dc_bundle),
    .i_dc_pc          (dc_pc),
    .i_dc_lsu_rd      (dc_lsu_rd),
    .i_dc_lsu_is_load (dc_lsu_is_load),
    .o_dc_hold        (dc_hold),
    .o_ex_slot_valid  (ex_slot_valid),
    .o_ex_bundle      (ex_bundle),
    .o_ex_pc          (ex_pc),
    .o_lsu_ex_rd      (lsu_ex_rd),
    .o_lsu_ex_is_load (lsu_ex_is_load),
    .o_stall_timeout  (stall_timeout),
    .o_perf_stall_cnt (perf_stall_cnt),
    .o_perf_flush_cnt (perf_flush_cnt),
    .o_dbg_state      (dbg_state),
    .o_dbg_stall_cnt  (dbg_stall_cnt)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one decode cycle and pushes what EX must show after the next edge.
  task automatic drive(input logic stall, input logic flush, input logic [3:0] v,
                       input logic [31:0] pc, input logic [4:0] rd, input logic ld,
                       input logic bubble);
    logic [EW-1:0] x;
    stall_in       = stall;
    flush_in       = flush;
    dc_slot_valid  = v;
    dc_pc          = pc;
    dc_lsu_rd      = rd;
    dc_lsu_is_load = ld;
    for (int k = 0; k < BW / 32; k++) dc_bundle[k*32 +: 32] = $urandom();
    if (bubble) x = '0;
    else x = {v, pc, (v[SLOT_LSU] ? rd : 5'd0), (v[SLOT_LSU] & ld & (rd != 5'd0))};
    exp_q.push_back(x);
    exp_bq.push_back(dc_bundle);
  endtask

  // PC is don't-care in a bubble, so it is masked when no slot is expected valid.
  function automatic logic [EW-1:0] exp_mask(input logic [EW-1:0] x);
    logic [EW-1:0] m;
    m = '1;
    if (x[EW-1 -: NUM_SLOTS] == '0) m[REG_W+1 +: PC_W] = '0;
    return m;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; stall_in = 1'b1; flush_in = 1'b0; dc_slot_valid = 4'hF;
    dc_pc = 32'hDEAD_BEEF; dc_lsu_rd = 5'd9; dc_lsu_is_load = 1'b1; dc_bundle = '1;
    step(); step();
    n_checks++; if (ex_slot_valid !== 4'h0) begin n_errors++; $display("FAIL reset_ex_valid: got %h want 0", ex_slot_valid); end
    n_checks++; if (ex_bundle !== '0) begin n_errors++; $display("FAIL reset_ex_bundle: got nonzero want 0"); end
    n_checks++; if (ex_pc !== 32'h0) begin n_errors++; $display("FAIL reset_ex_pc: got %h want 0", ex_pc); end
    n_checks++; if (lsu_ex_rd !== 5'd0 || lsu_ex_is_load !== 1'b0) begin n_errors++; $display("FAIL reset_lsu: got rd=%0d ld=%b want 0/0", lsu_ex_rd, lsu_ex_is_load); end
    n_checks++; if (dc_hold !== 1'b0) begin n_errors++; $display("FAIL reset_dc_hold: got %b want 0", dc_hold); end
    n_checks++; if (stall_timeout !== 1'b0) begin n_errors++; $display("FAIL reset_timeout: got %b want 0", stall_timeout); end
    n_checks++; if (perf_stall_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin n_errors++; $display("FAIL reset_perf: got %0d/%0d want 0/0", perf_stall_cnt, perf_flush_cnt); end
    n_checks++; if (dbg_state !== RUN || dbg_stall_cnt !== 4'd0) begin n_errors++; $display("FAIL reset_state: got %0d cnt %0d want RUN cnt 0", dbg_state, dbg_stall_cnt); end
    rst = 1'b0; stall_in = 1'b0; dc_slot_valid = 4'h0;
    step();
  endtask

  task automatic test_advance();
    logic [3:0] v;
    logic [4:0] rd;
    drive(1'b0, 1'b0, 4'b0101, 32'h100, 5'd7, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      e  = exp_q.pop_front();
      eb = exp_bq.pop_front();
      n_checks++;
      if ((w_obs & exp_mask(e)) !== (e & exp_mask(e))) begin
        n_errors++; $display("FAIL advance_ex[%0d]: got %h want %h", i, w_obs, e);
      end
      n_checks++;
      if (ex_bundle !== eb) begin n_errors++; $display("FAIL advance_bundle[%0d]: got %h want %h", i, ex_bundle[63:0], eb[63:0]); end
      v  = 4'($urandom_range(0, 15));
      rd = (i == 2) ? 5'd0 : 5'($urandom_range(0, 31));
      if (i == 3) v = 4'b1011;
      if (i < 9) drive(1'b0, 1'b0, v, $urandom(), rd, 1'($urandom_range(0, 1)) | (i == 2), 1'b0);
    end
  endtask

  task automatic test_stall();
    int seen;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) drive(1'b1, 1'b0, 4'hF, 32'h104, 5'd3, 1'b0, 1'b1);
      else drive(1'b0, 1'b0, 4'hF, (i == 3) ? 32'h104 : 32'h108, 5'd3, 1'b0, 1'b0);
      #1;
      n_checks++;
      if (dc_hold !== (i < 3)) begin n_errors++; $display("FAIL stall_hold[%0d]: got %b want %b", i, dc_hold, (i < 3)); end
      step();
      e = exp_q.pop_front();
      void'(exp_bq.pop_front());
      n_checks++;
      if ((w_obs & exp_mask(e)) !== (e & exp_mask(e))) begin
        n_errors++; $display("FAIL stall_ex[%0d]: got %h want %h", i, w_obs, e);
      end
      if (ex_slot_valid != 4'h0 && ex_pc == 32'h104) seen++;
    end
    n_checks++;
    if (seen != 1) begin n_errors++; $display("FAIL stall_pc_once: got %0d issues of 0x104 want 1", seen); end
  endtask

  task automatic test_flush();
    bit           s_t[7] = '{0, 1, 0, 0, 0, 0, 0};
    bit           f_t[7] = '{1, 0, 0, 1, 1, 0, 0};
    bit           b_t[7] = '{1, 1, 0, 1, 1, 1, 0};
    stall_state_e st_t[7] = '{FLUSH, RUN, RUN, FLUSH, FLUSH, RUN, RUN};
    for (int i = 0; i < 7; i++) begin
      drive(s_t[i], f_t[i], 4'hF, 32'h200 + 32'(i * 4), 5'd12, 1'b1, b_t[i]);
      #1;
      n_checks++;
      if (dc_hold !== 1'b0) begin n_errors++; $display("FAIL flush_hold[%0d]: got %b want 0", i, dc_hold); end
      step();
      e = exp_q.pop_front();
      void'(exp_bq.pop_front());
      n_checks++;
      if ((w_obs & exp_mask(e)) !== (e & exp_mask(e))) begin
        n_errors++; $display("FAIL flush_ex[%0d]: got %h want %h", i, w_obs, e);
      end
      n_checks++;
      if (dbg_state !== st_t[i]) begin n_errors++; $display("FAIL flush_state[%0d]: got %0d want %0d", i, dbg_state, st_t[i]); end
    end
  endtask

  task automatic test_stall_flush();
    for (int i = 0; i < 5; i++) begin
      drive(i < 3, i == 2, 4'hF, 32'h300 + 32'(i * 4), 5'd4, 1'b1, i < 4);
      #1;
      n_checks++;
      if (dc_hold !== (i < 2)) begin n_errors++; $display("FAIL sf_hold[%0d]: got %b want %b", i, dc_hold, (i < 2)); end
      step();
      e = exp_q.pop_front();
      void'(exp_bq.pop_front());
      n_checks++;
      if ((w_obs & exp_mask(e)) !== (e & exp_mask(e))) begin
        n_errors++; $display("FAIL sf_ex[%0d]: got %h want %h", i, w_obs, e);
      end
      if (i == 1) begin
        n_checks++;
        if (dbg_stall_cnt !== 4'd2) begin n_errors++; $display("FAIL sf_cnt_pre: got %0d want 2", dbg_stall_cnt); end
      end
      if (i == 2) begin
        n_checks++;
        if (dbg_state !== FLUSH || dbg_stall_cnt !== 4'd0) begin
          n_errors++; $display("FAIL sf_flush_wins: got state %0d cnt %0d want FLUSH cnt 0", dbg_state, dbg_stall_cnt);
        end
      end
    end
  endtask

  task automatic test_timeout();
    rst = 1'b1; stall_in = 1'b0; flush_in = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 4'h3, 32'h400, 5'd1, 1'b0, 1'b1);
      step();
      e = exp_q.pop_front();
      void'(exp_bq.pop_front());
      n_checks++;
      if ((w_obs & exp_mask(e)) !== (e & exp_mask(e))) begin
        n_errors++; $display("FAIL to_ex[%0d]: got %h want %h", i, w_obs, e);
      end
      if (i == 14) begin
        n_checks++;
        if (stall_timeout !== 1'b0 || dbg_stall_cnt !== 4'd15) begin
          n_errors++; $display("FAIL to_early: got to=%b cnt=%0d want to=0 cnt=15", stall_timeout, dbg_stall_cnt);
        end
      end
    end
    n_checks++;
    if (stall_timeout !== 1'b1) begin n_errors++; $display("FAIL to_set: got %b want 1", stall_timeout); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 4'h1, 32'h404 + 32'(i * 4), 5'd0, 1'b0, 1'b0);
      step();
      e = exp_q.pop_front();
      void'(exp_bq.pop_front());
      n_checks++;
      if ((w_obs & exp_mask(e)) !== (e & exp_mask(e))) begin
        n_errors++; $display("FAIL to_after_ex[%0d]: got %h want %h", i, w_obs, e);
      end
    end
    n_checks++;
    if (stall_timeout !== 1'b1 || dbg_stall_cnt !== 4'd0) begin
      n_errors++; $display("FAIL to_sticky: got to=%b cnt=%0d want to=1 cnt=0", stall_timeout, dbg_stall_cnt);
    end
`ifdef STALL_PERF_CNT_EN
    exp_perf_stall = 32'd16;
`else
    exp_perf_stall = 32'd0;
`endif
    n_checks++;
    if (perf_stall_cnt !== exp_perf_stall || perf_flush_cnt !== 32'd0) begin
      n_errors++; $display("FAIL to_perf: got %0d/%0d want %0d/0", perf_stall_cnt, perf_flush_cnt, exp_perf_stall);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (stall_timeout !== 1'b0) begin n_errors++; $display("FAIL to_rst_clear: got %b want 0", stall_timeout); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_advance();
    test_stall();
    test_flush();
    test_stall_flush();
    test_timeout();
    n_checks++;
    if (exp_q.size() != 0) begin n_errors++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
